data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words stored (power of two).
REQ-002 The module SHALL have parameter WAIT_STATES, default 2, giving the number of extra cycles inserted before Ack (0..15).
REQ-003 Port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port RST  input  1  asynchronous, active-low reset.
REQ-005 Port ReadEnable  input  1  read request, held high by the initiator until Ack.
REQ-006 Port WriteEnable  input  1  write request, held high by the initiator until Ack.
REQ-007 Port Address  input  32  byte address; bits [1:0] are ignored and word index = Address[log2(DEPTH_WORDS)+1:2].
REQ-008 Port WriteData  input  32  store data, lane i = bits [8i+7:8i].
REQ-009 Port ByteEnable  input  4  per-lane write strobe; bit i enables lane i.
REQ-010 Port ReadData  output  32  read result, valid in the Ack cycle of a read.
REQ-011 Port Ack  output  1  one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have the states IDLE, BUSY, ACK and DONE.
REQ-013 IDLE: when ReadEnable or WriteEnable is high, latch Address, WriteData, ByteEnable and request type; go to BUSY, or go to ACK directly if WAIT_STATES=0.
REQ-014 BUSY: decrement the wait counter, which was loaded with WAIT_STATES-1; at 0 go to ACK; the enables are not re-sampled.
REQ-015 ACK: Ack=1 for exactly one cycle; then go to DONE.
REQ-016 Latency: with the request sampled at edge 0, Ack SHALL be high during the cycle after edge WAIT_STATES+1.
REQ-017 A write SHALL commit on the edge entering ACK, updating only the lanes whose latched ByteEnable bit is 1; lanes with ByteEnable 0 are unchanged.
REQ-018 A read SHALL load ReadData with the addressed word on the edge entering ACK, reflecting all previously committed writes; ReadData holds until the next read completes.
REQ-019 DONE: remain while ReadEnable|WriteEnable is high, then go to IDLE; this prevents a held enable from being serviced twice.
REQ-020 ReadEnable and WriteEnable both high SHALL be treated as a write; ReadData is unchanged.
REQ-021 Input changes after the request has been latched SHALL NOT affect the transaction in progress.
REQ-022 Ack SHALL never be asserted in two consecutive cycles.

Reset
REQ-023 RST low SHALL immediately force state=IDLE, Ack=0, ReadData=0 and wait counter=0, independent of CLK.
REQ-024 RST asserted mid-transaction SHALL abort it; an uncommitted write is discarded and no Ack is issued.
REQ-025 Memory array contents SHALL NOT be reset.
REQ-026 After RST deasserts, a request SHALL be sampled no earlier than the first rising edge with RST high.

Configuration
REQ-027 Macro DATA_MEM_RESPONDER_BUS_ERROR_EN SHALL control out-of-range handling.
REQ-028 With the macro defined, there SHALL be an extra port BusError (output, 1 bit), pulsed with Ack when Address[31:2] >= DEPTH_WORDS; such a write is suppressed and such a read returns 32'h0000_0000; BusError resets to 0.
REQ-029 With the macro undefined, there SHALL be no BusError port and out-of-range addresses wrap modulo DEPTH_WORDS.

Verification
REQ-030 Scenario: WAIT_STATES=2, write 0xDEADBEEF to 0x10 with ByteEnable=4'hF, then read 0x10 -> each Ack arrives 3 cycles after its request is sampled; ReadData=0xDEADBEEF.
REQ-031 Scenario: word 0x20 holds 0x11223344; write 0xAABBCCDD with ByteEnable=4'b0101 -> a read returns 0x11BB33DD.
REQ-032 Scenario: WAIT_STATES=0 with ReadEnable held high 3 cycles after Ack -> exactly one Ack pulse; a new request is accepted only after the enable has been low for one cycle.
REQ-033 Scenario: RST pulled low one cycle into BUSY of a write of 0x55 to 0x8 -> Ack stays 0 and a later read of 0x8 returns its prior value.
REQ-034 Scenario: both enables high, address 0x4, data 0x1 -> treated as a write; ReadData unchanged; a later read of 0x4 returns 0x1.
REQ-035 Scenario: DEPTH_WORDS=1024, write 0x77 to 0x1000 -> with the macro defined, BusError=1 with Ack and word 0 is unchanged; with it undefined, word 0 becomes 0x77.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with byte-lane writes and a fixed-latency request/Ack handshake.
// Define DATA_MEM_RESPONDER_BUS_ERROR_EN to flag out-of-range addresses on BusError instead of wrapping.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ReadEnable,
  input  logic        WriteEnable,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEnable,
  output logic [31:0] ReadData,
`ifdef DATA_MEM_RESPONDER_BUS_ERROR_EN
  output logic        BusError,
`endif
  output logic        Ack
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, ACK, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            write_q, write_d;
  logic            oob_q, oob_d;
  logic            ack_q, ack_d;
`ifdef DATA_MEM_RESPONDER_BUS_ERROR_EN
  logic            berr_q, berr_d;
`endif

  logic            req;
  logic [AW-1:0]   live_idx;
  logic            live_oob;
  logic            enter_ack;
  logic            from_live;
  logic [AW-1:0]   c_idx;
  logic [31:0]     c_wdata;
  logic [3:0]      c_be;
  logic            c_write;
  logic            c_oob;
  logic            mem_we;
  logic            rd_load;
  logic            unused_addr;

  assign req         = ReadEnable | WriteEnable;
  assign live_idx    = Address[AW+1:2];
  assign unused_addr = ^{Address[1:0], Address[31:AW+2]};

`ifdef DATA_MEM_RESPONDER_BUS_ERROR_EN
  assign live_oob = {2'b00, Address[31:2]} >= 32'(DEPTH_WORDS);
`else
  assign live_oob = 1'b0;
`endif

  // With zero wait states the commit edge is the sampling edge, so the live inputs are used.
  assign from_live = (state_q == IDLE);
  assign enter_ack = ((state_q == IDLE) && req && (WAIT_STATES == 0)) ||
                     ((state_q == BUSY) && (cnt_q == 4'd0));
  assign c_idx   = from_live ? live_idx    : idx_q;
  assign c_wdata = from_live ? WriteData   : wdata_q;
  assign c_be    = from_live ? ByteEnable  : be_q;
  assign c_write = from_live ? WriteEnable : write_q;
  assign c_oob   = from_live ? live_oob    : oob_q;

  assign mem_we  = enter_ack && c_write && !c_oob && RST;
  assign rd_load = enter_ack && !c_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    write_d = write_q;
    oob_d   = oob_q;
    ack_d   = 1'b0;
`ifdef DATA_MEM_RESPONDER_BUS_ERROR_EN
    berr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = live_idx;
          wdata_d = WriteData;
          be_d    = ByteEnable;
          write_d = WriteEnable;
          oob_d   = live_oob;
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_STATES == 0) ? ACK : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        ack_d   = 1'b1;
`ifdef DATA_MEM_RESPONDER_BUS_ERROR_EN
        berr_d  = oob_q;
`endif
        state_d = DONE;
      end
      DONE: begin
        // Wait for the initiator to release its enable so one request is serviced once.
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      write_q <= 1'b0;
      oob_q   <= 1'b0;
      ack_q   <= 1'b0;
`ifdef DATA_MEM_RESPONDER_BUS_ERROR_EN
      berr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      write_q <= write_d;
      oob_q   <= oob_d;
      ack_q   <= ack_d;
`ifdef DATA_MEM_RESPONDER_BUS_ERROR_EN
      berr_q  <= berr_d;
`endif
    end
  end

  assign Ack = ack_q;
`ifdef DATA_MEM_RESPONDER_BUS_ERROR_EN
  assign BusError = berr_q;
`endif

  // One byte-wide array per lane keeps the strobed write a plain per-lane write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge CLK) begin
      if (mem_we && c_be[gi]) begin
        lane_mem[c_idx] <= c_wdata[8*gi +: 8];
      end
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        rd_q <= 8'h00;
      end else if (rd_load) begin
        rd_q <= c_oob ? 8'h00 : lane_mem[c_idx];
      end
    end

    assign ReadData[8*gi +: 8] = rd_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: one DUT with two wait states and one with none, sharing clock and reset.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        re_s   [2];
  logic        we_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s   [2];
  logic [3:0]  be_s   [2];
  logic [31:0] rd_s   [2];
  logic        ack_s  [2];
`ifdef DATA_MEM_RESPONDER_BUS_ERROR_EN
  logic        berr_s [2];
`endif

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut (
    .CLK(clk), .RST(rst_n),
    .ReadEnable(re_s[0]), .WriteEnable(we_s[0]),
    .Address(addr_s[0]), .WriteData(wd_s[0]), .ByteEnable(be_s[0]),
    .ReadData(rd_s[0]),
`ifdef DATA_MEM_RESPONDER_BUS_ERROR_EN
    .BusError(berr_s[0]),
`endif
    .Ack(ack_s[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut_z (
    .CLK(clk), .RST(rst_n),
    .ReadEnable(re_s[1]), .WriteEnable(we_s[1]),
    .Address(addr_s[1]), .WriteData(wd_s[1]), .ByteEnable(be_s[1]),
    .ReadData(rd_s[1]),
`ifdef DATA_MEM_RESPONDER_BUS_ERROR_EN
    .BusError(berr_s[1]),
`endif
    .Ack(ack_s[1])
  );

  typedef struct {
    logic [31:0] rdata;
    int          ack_cyc;
    bit          berr;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  bit   prev_ack [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every Ack pops the oldest expectation of its DUT.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ack_s[k] === 1'b1) begin
        check($sformatf("ack_isolated[%0d]", k), {31'b0, prev_ack[k]}, 32'd0);
        if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack[%0d]: Ack=1 with no outstanding request at cycle %0d", k, cyc);
        end else begin
          if (k == 0) mon_e = sb0.pop_front();
          else        mon_e = sb1.pop_front();
          check($sformatf("ack_latency[%0d]", k), 32'(cyc), 32'(mon_e.ack_cyc));
          check($sformatf("read_data[%0d]", k), rd_s[k], mon_e.rdata);
`ifdef DATA_MEM_RESPONDER_BUS_ERROR_EN
          check($sformatf("bus_error[%0d]", k), {31'b0, berr_s[k]}, {31'b0, mon_e.berr});
`endif
        end
      end
      prev_ack[k] = (ack_s[k] === 1'b1);
    end
  end

  // Issue one request on DUT k; inputs are scrambled after the sampling edge.
  task automatic txn(input int k, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     input logic [31:0] exp_rd, input bit exp_berr, input int hold);
    exp_t e;
    bit   got;
    int   ws;
    ws        = (k == 0) ? 2 : 0;
    e.rdata   = exp_rd;
    e.ack_cyc = cyc + ws + 2;
    e.berr    = exp_berr;
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    re_s[k] = r; we_s[k] = w; addr_s[k] = a; wd_s[k] = d; be_s[k] = be;
    @(posedge clk);
    #1;
    addr_s[k] = ~a; wd_s[k] = ~d; be_s[k] = ~be;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (ack_s[k] === 1'b1) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL ack_timeout[%0d]: no Ack within 30 cycles for address 0x%08h", k, a);
    end
    repeat (hold) @(negedge clk);
    re_s[k] = 1'b0; we_s[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      re_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = 32'd0; wd_s[k] = 32'd0; be_s[k] = 4'd0;
    end
    #1;
    check("reset_ack",   {31'b0, ack_s[0]}, 32'd0);
    check("reset_rdata", rd_s[0], 32'd0);
    check("reset_ack_z", {31'b0, ack_s[1]}, 32'd0);
    check("reset_rdata_z", rd_s[1], 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero wait states: held enable serviced once, then re-accepted after one low cycle.
    txn(1, 1'b0, 1'b1, 32'h40, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0, 0);
    txn(1, 1'b1, 1'b0, 32'h40, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0, 3);
    txn(1, 1'b1, 1'b0, 32'h40, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0, 0);

    // Two wait states: full write/read, partial byte lanes, simultaneous enables.
    txn(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF,    32'h0000_0000, 1'b0, 0);
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0,         4'h0,    32'hDEAD_BEEF, 1'b0, 0);
    txn(0, 1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF,    32'hDEAD_BEEF, 1'b0, 0);
    txn(0, 1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'hDEAD_BEEF, 1'b0, 0);
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0, 0);
    txn(0, 1'b1, 1'b1, 32'h4,  32'h0000_0001, 4'hF,    32'h11BB_33DD, 1'b0, 0);
    txn(0, 1'b1, 1'b0, 32'h4,  32'h0,         4'h0,    32'h0000_0001, 1'b0, 0);
    txn(0, 1'b0, 1'b1, 32'h8,  32'hCAFE_F00D, 4'hF,    32'h0000_0001, 1'b0, 0);

    // Reset one cycle into BUSY of a write: no Ack, nothing committed.
    we_s[0] = 1'b1; addr_s[0] = 32'h8; wd_s[0] = 32'h55; be_s[0] = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ack",   {31'b0, ack_s[0]}, 32'd0);
    check("abort_rdata", rd_s[0], 32'd0);
    we_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0);

    // Out-of-range address: wraps to word 0, or flags BusError when enabled.
    txn(0, 1'b0, 1'b1, 32'h0,    32'h1234_5678, 4'hF, 32'hCAFE_F00D, 1'b0, 0);
`ifdef DATA_MEM_RESPONDER_BUS_ERROR_EN
    txn(0, 1'b0, 1'b1, 32'h1000, 32'h0000_0077, 4'hF, 32'hCAFE_F00D, 1'b1, 0);
    txn(0, 1'b1, 1'b0, 32'h0,    32'h0,         4'h0, 32'h1234_5678, 1'b0, 0);
    txn(0, 1'b1, 1'b0, 32'h1000, 32'h0,         4'h0, 32'h0000_0000, 1'b1, 0);
`else
    txn(0, 1'b0, 1'b1, 32'h1000, 32'h0000_0077, 4'hF, 32'hCAFE_F00D, 1'b0, 0);
    txn(0, 1'b1, 1'b0, 32'h0,    32'h0,         4'h0, 32'h0000_0077, 1'b0, 0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb0.size() + sb1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
